// File: rtl/fixed_point_mul_pipe.sv
// Pipelined signed fixed-point multiplier, Q(TOTAL_W-FRAC_W).FRAC_W format.
// The pipe has a valid/ready handshake, optional round-half-up and
// saturate-or-wrap. It flags overflow on every result and keeps a sticky copy.
// The whole pipe advances together; a downstream stall freezes every stage,
// including empty ones, so the latency is always exactly STAGES cycles.
// For STAGES >= 3 the stages are: operand register, product register(s),
// then a round/saturate output register. Shallower pipes fold these together.
module fixed_point_mul_pipe #(
    parameter int TOTAL_W  = 32,
    parameter int FRAC_W   = 16,
    parameter int STAGES   = 3,
    parameter int ROUND    = 0,
    parameter int SATURATE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [TOTAL_W-1:0] op1,
    input  logic [TOTAL_W-1:0] op2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TOTAL_W-1:0] result,
    output logic               overflow,
    output logic               ovf_sticky,
    input  logic               ovf_clear
);

    // Registering the operands only pays off when there is room for a
    // separate product stage behind it.
    localparam int OPS_REG = (STAGES >= 3) ? 1 : 0;
    localparam int PROD_N  = STAGES - 1 - OPS_REG;
    localparam int PW      = 2 * TOTAL_W;

    logic                      adv_s;
    logic                      in_fire_s;
    logic                      ovf_set_s;
    logic [STAGES-1:0]         valid_r;
    logic signed [TOTAL_W-1:0] mul_a_s;
    logic signed [TOTAL_W-1:0] mul_b_s;
    logic signed [PW-1:0]      prod_s;
    logic signed [PW-1:0]      sat_in_s;
    logic [TOTAL_W:0]          sat_s;
    logic [TOTAL_W-1:0]        result_r;
    logic                      overflow_r;
    logic                      ovf_sticky_r;

    // Round the full-precision product and shift it down to the Q format.
    // Then range-check it and clamp or wrap it. Returns {ovf, result}.
    function automatic logic [TOTAL_W:0] round_sat(input logic signed [PW-1:0] p);
        logic signed [PW:0] rnd_v;
        logic signed [PW:0] ext_v;
        logic signed [PW:0] shr_v;
        logic signed [PW:0] max_v;
        logic signed [PW:0] min_v;
        logic               ovf_v;
        logic [TOTAL_W-1:0] res_v;
        rnd_v = '0;
        if (ROUND != 0) begin
            rnd_v[FRAC_W-1] = 1'b1;
        end else begin
            rnd_v = '0;
        end
        // One extra bit so the rounding add can never wrap.
        ext_v = $signed({p[PW-1], p}) + rnd_v;
        shr_v = ext_v >>> FRAC_W;
        max_v = '0;
        max_v[TOTAL_W-2:0] = '1;
        min_v = '1;
        min_v[TOTAL_W-2:0] = '0;
        ovf_v = (shr_v > max_v) || (shr_v < min_v);
        if (ovf_v && (SATURATE != 0)) begin
            res_v = shr_v[PW] ? {1'b1, {(TOTAL_W-1){1'b0}}} : {1'b0, {(TOTAL_W-1){1'b1}}};
        end else begin
            res_v = shr_v[TOTAL_W-1:0];
        end
        return {ovf_v, res_v};
    endfunction

    assign adv_s     = !valid_r[STAGES-1] || out_ready;
    assign in_fire_s = in_valid && adv_s;
    assign ovf_set_s = valid_r[STAGES-1] && out_ready && overflow_r;

    // Valid bits march with the pipe; a bubble occupies a stage like a token.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
        end else if (adv_s) begin
            valid_r[0] <= in_fire_s;
            for (int i = 1; i < STAGES; i++) begin
                valid_r[i] <= valid_r[i-1];
            end
        end
    end

    generate
        if (OPS_REG == 1) begin : g_ops_reg
            logic signed [TOTAL_W-1:0] op1_r;
            logic signed [TOTAL_W-1:0] op2_r;

            // Operand capture stage, keeps the input ports off the multiplier path.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    op1_r <= '0;
                    op2_r <= '0;
                end else if (adv_s) begin
                    op1_r <= op1;
                    op2_r <= op2;
                end
            end

            assign mul_a_s = op1_r;
            assign mul_b_s = op2_r;
        end else begin : g_ops_direct
            assign mul_a_s = op1;
            assign mul_b_s = op2;
        end
    endgenerate

    // Full-width signed product, exact for every operand pair.
    assign prod_s = $signed({{TOTAL_W{mul_a_s[TOTAL_W-1]}}, mul_a_s})
                  * $signed({{TOTAL_W{mul_b_s[TOTAL_W-1]}}, mul_b_s});

    generate
        if (PROD_N > 0) begin : g_prod_pipe
            logic signed [PW-1:0] prod_r [PROD_N];

            // Product register plus any extra delay stages needed for the latency.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PROD_N; i++) begin
                        prod_r[i] <= '0;
                    end
                end else if (adv_s) begin
                    prod_r[0] <= prod_s;
                    for (int i = 1; i < PROD_N; i++) begin
                        prod_r[i] <= prod_r[i-1];
                    end
                end
            end

            assign sat_in_s = prod_r[PROD_N-1];
        end else begin : g_prod_direct
            assign sat_in_s = prod_s;
        end
    endgenerate

    // Round/saturate logic ahead of the output register.
    always_comb begin
        sat_s = round_sat(sat_in_s);
    end

    // Output register. It holds its value whenever the pipe is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r   <= '0;
            overflow_r <= 1'b0;
        end else if (adv_s) begin
            result_r   <= sat_s[TOTAL_W-1:0];
            overflow_r <= sat_s[TOTAL_W];
        end
    end

    // Sticky overflow: set by an overflowing delivered result, which wins over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky_r <= 1'b0;
        end else if (ovf_set_s) begin
            ovf_sticky_r <= 1'b1;
        end else if (ovf_clear) begin
            ovf_sticky_r <= 1'b0;
        end
    end

    assign in_ready   = adv_s;
    assign out_valid  = valid_r[STAGES-1];
    assign result     = result_r;
    assign overflow   = overflow_r;
    assign ovf_sticky = ovf_sticky_r;

endmodule

// File: tb/tb_fixed_point_mul_pipe.sv
// Bench for fixed_point_mul_pipe in Q8.8. Three instances share one stimulus.
// t: 3 stages, truncate, saturate. r: 3 stages, round, saturate.
// w: 1 stage, truncate, wrap.
module tb_fixed_point_mul_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        ovf_clear;
    logic [15:0] op1;
    logic [15:0] op2;

    logic        rdy_t, vld_t, ovf_t, stk_t;
    logic [15:0] res_t;
    logic        rdy_r, vld_r, ovf_r, stk_r;
    logic [15:0] res_r;
    logic        rdy_w, vld_w, ovf_w, stk_w;
    logic [15:0] res_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fixed_point_mul_pipe #(.TOTAL_W(16), .FRAC_W(8), .STAGES(3), .ROUND(0), .SATURATE(1)) dut_t (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_t), .op1(op1), .op2(op2),
        .out_valid(vld_t), .out_ready(out_ready), .result(res_t), .overflow(ovf_t),
        .ovf_sticky(stk_t), .ovf_clear(ovf_clear));

    fixed_point_mul_pipe #(.TOTAL_W(16), .FRAC_W(8), .STAGES(3), .ROUND(1), .SATURATE(1)) dut_r (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_r), .op1(op1), .op2(op2),
        .out_valid(vld_r), .out_ready(out_ready), .result(res_r), .overflow(ovf_r),
        .ovf_sticky(stk_r), .ovf_clear(ovf_clear));

    fixed_point_mul_pipe #(.TOTAL_W(16), .FRAC_W(8), .STAGES(1), .ROUND(0), .SATURATE(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w), .op1(op1), .op2(op2),
        .out_valid(vld_w), .out_ready(out_ready), .result(res_w), .overflow(ovf_w),
        .ovf_sticky(stk_w), .ovf_clear(ovf_clear));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_t;
        logic [15:0] exp_r;
        logic [15:0] exp_w;
        logic        exp_ovf;
    } vec_t;

    typedef struct {
        logic        v;
        logic [15:0] rt;
        logic        ot;
        logic [15:0] rr;
        logic        orr;
    } slot_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: exact integer product, optional +0.5 LSB, floor shift, range check.
    function automatic logic [16:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input bit rnd, input bit sat);
        longint      p;
        longint      s;
        logic        ov;
        logic [15:0] r;
        p = longint'($signed(a)) * longint'($signed(b));
        if (rnd) p = p + 128;
        s = p >>> 8;
        ov = (s > 32767) || (s < -32768);
        if (ov && sat) r = (s > 0) ? 16'h7FFF : 16'h8000;
        else r = s[15:0];
        return {ov, r};
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] v;
        case ($urandom_range(0, 3))
            0: v = 16'($urandom);
            1: v = 16'($urandom_range(0, 1023)) - 16'd512;
            2: begin
                case ($urandom_range(0, 5))
                    0: v = 16'h8000;
                    1: v = 16'h7FFF;
                    2: v = 16'hFFFF;
                    3: v = 16'h0100;
                    4: v = 16'hFF00;
                    default: v = 16'h0000;
                endcase
            end
            default: v = 16'($urandom_range(0, 4095)) - 16'd2048;
        endcase
        return v;
    endfunction

    task automatic drain();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ovf_clear = 1'b1;
        repeat (4) @(negedge clk);
        ovf_clear = 1'b0;
    endtask

    // One transaction through all three instances, checking latency, value and sticky.
    task automatic run_vec(input string tag, input vec_t v);
        int          lat_t, lat_r, lat_w;
        logic [15:0] c_rt, c_rr, c_rw;
        logic        c_ot, c_or, c_ow;
        lat_t = 0; lat_r = 0; lat_w = 0;
        c_rt = '0; c_rr = '0; c_rw = '0;
        c_ot = 1'b0; c_or = 1'b0; c_ow = 1'b0;
        @(negedge clk);
        op1 = v.a; op2 = v.b;
        in_valid = 1'b1; out_ready = 1'b1; ovf_clear = 1'b1;
        #1;
        chk({tag, "_in_ready"}, rdy_t, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; ovf_clear = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (vld_t && lat_t == 0) begin lat_t = n; c_rt = res_t; c_ot = ovf_t; end
            if (vld_r && lat_r == 0) begin lat_r = n; c_rr = res_r; c_or = ovf_r; end
            if (vld_w && lat_w == 0) begin lat_w = n; c_rw = res_w; c_ow = ovf_w; end
        end
        chk({tag, "_lat_t"}, lat_t, 3);
        chk({tag, "_lat_r"}, lat_r, 3);
        chk({tag, "_lat_w"}, lat_w, 1);
        chk({tag, "_res_t"}, c_rt, v.exp_t);
        chk({tag, "_res_r"}, c_rr, v.exp_r);
        chk({tag, "_res_w"}, c_rw, v.exp_w);
        chk({tag, "_ovf_t"}, c_ot, v.exp_ovf);
        chk({tag, "_ovf_r"}, c_or, v.exp_ovf);
        chk({tag, "_ovf_w"}, c_ow, v.exp_ovf);
        chk({tag, "_stk_t"}, stk_t, v.exp_ovf);
        chk({tag, "_stk_r"}, stk_r, v.exp_ovf);
        chk({tag, "_stk_w"}, stk_w, v.exp_ovf);
    endtask

    // Random stream with random backpressure against a frozen-pipe model.
    task automatic rand_stream(input int n_txn);
        slot_t       pipe[3];
        int          sent, got, cyc;
        logic        adv, fire_in, fire_out;
        logic        es_t, es_r;
        logic [16:0] m;
        sent = 0; got = 0; cyc = 0;
        es_t = 1'b0; es_r = 1'b0;
        for (int i = 0; i < 3; i++) pipe[i] = '{1'b0, 16'h0, 1'b0, 16'h0, 1'b0};
        while (got < n_txn && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            chk("rs_stk_t", stk_t, es_t);
            chk("rs_stk_r", stk_r, es_r);
            in_valid  = (sent < n_txn) ? 1'($urandom_range(0, 1)) : 1'b0;
            op1       = rand_op();
            op2       = rand_op();
            out_ready = 1'($urandom_range(0, 1));
            ovf_clear = ($urandom_range(0, 7) == 0);
            #1;
            adv = !pipe[2].v || out_ready;
            chk("rs_in_ready", rdy_t, adv);
            chk("rs_vld_t", vld_t, pipe[2].v);
            chk("rs_vld_r", vld_r, pipe[2].v);
            if (pipe[2].v) begin
                chk("rs_res_t", res_t, pipe[2].rt);
                chk("rs_ovf_t", ovf_t, pipe[2].ot);
                chk("rs_res_r", res_r, pipe[2].rr);
                chk("rs_ovf_r", ovf_r, pipe[2].orr);
            end
            fire_out = pipe[2].v && out_ready;
            fire_in  = in_valid && adv;
            if (fire_out && pipe[2].ot) es_t = 1'b1;
            else if (ovf_clear) es_t = 1'b0;
            if (fire_out && pipe[2].orr) es_r = 1'b1;
            else if (ovf_clear) es_r = 1'b0;
            if (fire_out) got++;
            if (fire_in) sent++;
            if (adv) begin
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0].v = fire_in;
                m = ref_mul(op1, op2, 1'b0, 1'b1);
                pipe[0].rt = m[15:0]; pipe[0].ot = m[16];
                m = ref_mul(op1, op2, 1'b1, 1'b1);
                pipe[0].rr = m[15:0]; pipe[0].orr = m[16];
            end
            @(posedge clk);
        end
        chk("rs_all_delivered", got, n_txn);
    endtask

    initial begin
        vec_t v;
        logic seen;
        // a, b, trunc+sat, round+sat, trunc+wrap, overflow
        vecs[0] = '{16'h0180, 16'h0200, 16'h0300, 16'h0300, 16'h0300, 1'b0};
        vecs[1] = '{16'hFE80, 16'h0200, 16'hFD00, 16'hFD00, 16'hFD00, 1'b0};
        vecs[2] = '{16'h6400, 16'h6400, 16'h7FFF, 16'h7FFF, 16'h1000, 1'b1};
        vecs[3] = '{16'h8000, 16'hFF00, 16'h7FFF, 16'h7FFF, 16'h8000, 1'b1};
        vecs[4] = '{16'h8000, 16'h0100, 16'h8000, 16'h8000, 16'h8000, 1'b0};
        vecs[5] = '{16'h0001, 16'h0080, 16'h0000, 16'h0001, 16'h0000, 1'b0};
        vecs[6] = '{16'hFFFF, 16'h0080, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h0000, 1'b1};
        vecs[8] = '{16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[9] = '{16'h8000, 16'h7FFF, 16'h8000, 16'h8000, 16'h0080, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clear = 1'b0;
        op1 = 16'h0; op2 = 16'h0;
        #23;
        chk("rst_vld_t", vld_t, 1'b0);
        chk("rst_res_t", res_t, 16'h0000);
        chk("rst_ovf_t", ovf_t, 1'b0);
        chk("rst_stk_t", stk_t, 1'b0);
        chk("rst_vld_w", vld_w, 1'b0);
        chk("rst_in_ready", rdy_t, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            run_vec($sformatf("vec%0d", i), v);
        end

        drain();
        rand_stream(40);
        drain();

        // Clear and an overflowing delivery on the same edge: set wins.
        @(negedge clk); ovf_clear = 1'b1;
        @(posedge clk); #1 ovf_clear = 1'b0;
        chk("sw_pre_clear", stk_t, 1'b0);
        @(negedge clk);
        op1 = vecs[2].a; op2 = vecs[2].b; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            @(negedge clk);
            if (vld_t) seen = 1'b1;
        end
        chk("sw_wait_valid", seen, 1'b1);
        ovf_clear = 1'b1;
        @(posedge clk); #1 ovf_clear = 1'b0;
        chk("sw_set_wins_t", stk_t, 1'b1);
        chk("sw_set_wins_r", stk_r, 1'b1);
        @(negedge clk); ovf_clear = 1'b1;
        @(posedge clk); #1 ovf_clear = 1'b0;
        chk("sw_clear_t", stk_t, 1'b0);

        // Reset with three operands in flight; sticky was set beforehand.
        drain();
        run_vec("pre_rst", vecs[2]);
        @(negedge clk);
        op1 = vecs[0].a; op2 = vecs[0].b; in_valid = 1'b1; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mr_stk_before", stk_t, 1'b1);
        chk("mr_vld_before", vld_t, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_vld_t", vld_t, 1'b0);
        chk("mr_vld_r", vld_r, 1'b0);
        chk("mr_vld_w", vld_w, 1'b0);
        chk("mr_stk_t", stk_t, 1'b0);
        chk("mr_stk_w", stk_w, 1'b0);
        chk("mr_res_t", res_t, 16'h0000);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("post_rst", vecs[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fixed_point_mul_pipe.md
Name: fixed_point_mul_pipe

Overview:
Pipelined, parametrised signed fixed-point multiplier with valid/ready handshake, selectable rounding, saturation and a correct per-result overflow flag. It also keeps a sticky overflow status. It sits in the gfx datapath between vertex/transform stages and replaces single-cycle combinational multiplies on timing-critical paths. Format is two's-complement Q(TOTAL_W-FRAC_W).FRAC_W.

Parameters:
TOTAL_W, 32, total operand/result width in bits (>=4)
FRAC_W, 16, fraction bits (1 <= FRAC_W < TOTAL_W)
STAGES, 3, pipeline depth in cycles (>=1)
ROUND, 0, 0 = truncate (floor via arithmetic shift), 1 = round half up (add 2^(FRAC_W-1) before shift)
SATURATE, 1, 1 = clamp on overflow, 0 = wrap (keep low TOTAL_W bits)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  op1/op2 valid
in_ready  output  1  block can accept operands this cycle
op1  input  TOTAL_W  signed multiplicand
op2  input  TOTAL_W  signed multiplier
out_valid  output  1  result/overflow valid
out_ready  input  1  downstream accepts result
result  output  TOTAL_W  signed product, same Q format
overflow  output  1  this result was not representable (clamped or wrapped)
ovf_sticky  output  1  set by any overflowing accepted result
ovf_clear  input  1  synchronous clear of ovf_sticky

Behaviour:
- Reset (async assert, sync deassert at the design level): all stage valid bits 0, out_valid=0, result=0, overflow=0, ovf_sticky=0. Data registers are reset to 0. Reset mid-operation discards all in-flight operands.
- Global pipeline enable: adv = !out_valid || out_ready. All stages shift when adv=1 and hold otherwise. in_ready = adv, combinational, with no path from in_valid.
- Transfer occurs when in_valid && in_ready. The operand pair enters stage 0, and its valid bit is in_valid&&in_ready.
- Latency: a result appears on out_valid exactly STAGES cycles after acceptance when out_ready is held 1. Throughput is 1 per cycle. Bubbles do not collapse: a stall freezes the whole pipe, including empty stages.
- Output is held stable (result, overflow) while out_valid && !out_ready.
- Arithmetic:
  - p = signed(op1) * signed(op2), 2*TOTAL_W bits, exact.
  - If ROUND=1: p' = p + 2^(FRAC_W-1), computed with no wrap (1 extra bit). Otherwise p' = p.
  - s = p' >>> FRAC_W (arithmetic shift).
  - ovf = s outside [-2^(TOTAL_W-1), 2^(TOTAL_W-1)-1].
  - If SATURATE=1 and ovf: result = max when s>0, min when s<0. Otherwise result = s[TOTAL_W-1:0].
  - overflow = ovf in both modes.
- Multiply, round and saturate logic may be distributed over stages freely, provided the latency and results above hold.
- ovf_sticky:
  - Set in the cycle after an out_valid && out_ready transfer with overflow=1.
  - ovf_clear=1 clears it in the next cycle.
  - If clear and set occur in the same cycle, set wins.
- Edge cases:
  - min*min and min*(-1.0) overflow positively → saturate to max.
  - Zero operands never flag overflow.
  - STAGES=1 is a single register stage.

Test Plan:
- W=16, F=8, ROUND=0, SAT=1: op1=0x0180, op2=0x0200 (1.5*2.0) → result 0x0300, overflow 0, out_valid exactly 3 cycles after accept.
- op1=0xFE80, op2=0x0200 (-1.5*2.0) → 0xFD00, overflow 0. Then op1=0x6400, op2=0x6400 (100*100) → 0x7FFF, overflow 1, ovf_sticky=1 next cycle. With SAT=0 the same inputs give 0x1000, overflow 1.
- op1=0x8000, op2=0xFF00 (-128*-1) → 0x7FFF, overflow 1. op1=0x8000, op2=0x0100 → 0x8000, overflow 0.
- Rounding, op1=0x0001, op2=0x0080: ROUND=0 → 0x0000, ROUND=1 → 0x0001. With op1=0xFFFF, op2=0x0080: ROUND=0 → 0xFFFF, ROUND=1 → 0x0000.
- Backpressure: stream 8 random pairs with out_ready toggled pseudo-randomly. Required: no loss, no duplication, in order, output stable while stalled, in_ready==adv, results match the reference model.
- Assert rst_n mid-stream with 3 results in flight → out_valid=0 and ovf_sticky=0 immediately. First post-reset accept produces a correct result after STAGES cycles. Also check: ovf_clear asserted in the same cycle as an overflowing transfer leaves ovf_sticky=1.
